// File: rtl/race_sequencer.sv
// Game flow sequencer for epic_racer: IDLE -> COUNTDOWN -> RACE (<-> CRASH) -> FINISH.
// Drives layer visibility, gates car movement and keeps lap / race-time counters for the HUD.
module race_sequencer #(
  parameter int COUNT_FRAMES = 60,
  parameter int CRASH_FRAMES = 90,
  parameter int LAPS         = 3,
  parameter int TIME_W       = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              vblnk,
  input  logic [3:0]        key,
  input  logic              lap_pulse,
  input  logic              crash,
  output logic              bg_visible,
  output logic              track_visible,
  output logic              player_visible,
  output logic              car_en,
  output logic [1:0]        countdown,
  output logic [2:0]        lap_cnt,
  output logic [TIME_W-1:0] frame_time,
  output logic [2:0]        state
);

  localparam int CW = $clog2(COUNT_FRAMES + 1);
  localparam int RW = $clog2(CRASH_FRAMES + 1);
  localparam logic [CW-1:0] STEP_LAST  = CW'(COUNT_FRAMES - 1);
  localparam logic [RW-1:0] CRASH_LAST = RW'(CRASH_FRAMES - 1);
  localparam logic [2:0]    LAP_TGT    = 3'(LAPS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_RACE   = 3'd2,
    S_CRASH  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       step_q, step_d;
  logic [RW-1:0]       crash_cnt_q, crash_cnt_d;
  logic [1:0]          cd_q, cd_d;
  logic [2:0]          lap_q, lap_d;
  logic [TIME_W-1:0]   ft_q, ft_d;
  logic                vblnk_dly_q, key_dly_q;
  logic                bg_q, vis_q, car_en_q;
  logic                tick, press;

  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return (v == '1) ? v : v + TIME_W'(1);
  endfunction

  // Delay registers reset high so a level already present at reset is not an edge.
  assign tick  = vblnk & ~vblnk_dly_q;
  assign press = (|key) & ~key_dly_q;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    crash_cnt_d = crash_cnt_q;
    cd_d        = cd_q;
    lap_d       = lap_q;
    ft_d        = ft_q;
    case (state_q)
      S_IDLE: if (press) begin
        state_d = S_COUNT;
        cd_d    = 2'd3;
        step_d  = '0;
        lap_d   = '0;
        ft_d    = '0;
      end
      S_COUNT: if (tick) begin
        if (step_q == STEP_LAST) begin
          step_d = '0;
          cd_d   = cd_q - 2'd1;
          if (cd_q == 2'd1) state_d = S_RACE;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      S_RACE: begin
        if (tick) ft_d = sat_inc(ft_q);
        // A lap completion outranks a simultaneous crash so the finish is never lost.
        if (lap_pulse) begin
          lap_d = lap_q + 3'd1;
          if (lap_q + 3'd1 == LAP_TGT) state_d = S_FINISH;
        end else if (crash) begin
          state_d     = S_CRASH;
          crash_cnt_d = '0;
        end
      end
      S_CRASH: if (tick) begin
        ft_d = sat_inc(ft_q);
        if (crash_cnt_q == CRASH_LAST) begin
          crash_cnt_d = '0;
          state_d     = S_RACE;
        end else begin
          crash_cnt_d = crash_cnt_q + RW'(1);
        end
      end
      S_FINISH: if (press) begin
        state_d     = S_IDLE;
        cd_d        = 2'd3;
        step_d      = '0;
        crash_cnt_d = '0;
        lap_d       = '0;
        ft_d        = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      crash_cnt_q <= '0;
      cd_q        <= 2'd3;
      lap_q       <= '0;
      ft_q        <= '0;
      vblnk_dly_q <= 1'b1;
      key_dly_q   <= 1'b1;
      bg_q        <= 1'b1;
      vis_q       <= 1'b0;
      car_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      crash_cnt_q <= crash_cnt_d;
      cd_q        <= cd_d;
      lap_q       <= lap_d;
      ft_q        <= ft_d;
      vblnk_dly_q <= vblnk;
      key_dly_q   <= |key;
      bg_q        <= 1'b1;
      vis_q       <= (state_d != S_IDLE);
      car_en_q    <= (state_d == S_RACE);
    end
  end

  assign bg_visible     = bg_q;
  assign track_visible  = vis_q;
  assign player_visible = vis_q;
  assign car_en         = car_en_q;
  assign countdown      = cd_q;
  assign lap_cnt        = lap_q;
  assign frame_time     = ft_q;
  assign state          = state_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Bench for race_sequencer: directed game scenarios followed by randomized play,
// all outputs compared each cycle against a frame-count reference model.
module tb_race_sequencer;

  localparam int CF     = 2;
  localparam int CRF    = 3;
  localparam int NLAPS  = 2;
  localparam int TW     = 5;
  localparam int FT_MAX = (1 << TW) - 1;

  logic          pclk = 1'b0;
  logic          rst  = 1'b1;
  logic          vblnk = 1'b0;
  logic [3:0]    key = 4'b0001;
  logic          lap_pulse = 1'b0;
  logic          crash = 1'b0;
  logic          bg_visible, track_visible, player_visible, car_en;
  logic [1:0]    countdown;
  logic [2:0]    lap_cnt;
  logic [TW-1:0] frame_time;
  logic [2:0]    state;

  race_sequencer #(
    .COUNT_FRAMES(CF), .CRASH_FRAMES(CRF), .LAPS(NLAPS), .TIME_W(TW)
  ) dut (
    .pclk(pclk), .rst(rst), .vblnk(vblnk), .key(key),
    .lap_pulse(lap_pulse), .crash(crash),
    .bg_visible(bg_visible), .track_visible(track_visible),
    .player_visible(player_visible), .car_en(car_en),
    .countdown(countdown), .lap_cnt(lap_cnt), .frame_time(frame_time), .state(state)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase plus frames elapsed in the current timed phase.
  int m_phase, m_cd_frames, m_crash_frames, m_laps, m_ft;
  bit m_vd, m_kd;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cd_frames = 0; m_crash_frames = 0; m_laps = 0; m_ft = 0;
    m_vd = 1'b1; m_kd = 1'b1;
  endtask

  task automatic model_step(input bit v, input logic [3:0] k, input bit lp, input bit cr);
    bit tk, pr;
    tk = v && !m_vd;
    pr = (k != 4'b0) && !m_kd;
    m_vd = v;
    m_kd = (k != 4'b0);
    case (m_phase)
      0: if (pr) begin m_phase = 1; m_cd_frames = 0; m_laps = 0; m_ft = 0; end
      1: if (tk) begin
        m_cd_frames++;
        if (m_cd_frames == 3 * CF) m_phase = 2;
      end
      2: begin
        if (tk && m_ft < FT_MAX) m_ft++;
        if (lp) begin
          m_laps++;
          if (m_laps == NLAPS) m_phase = 4;
        end else if (cr) begin
          m_phase = 3; m_crash_frames = 0;
        end
      end
      3: if (tk) begin
        if (m_ft < FT_MAX) m_ft++;
        m_crash_frames++;
        if (m_crash_frames == CRF) m_phase = 2;
      end
      4: if (pr) begin m_phase = 0; m_laps = 0; m_ft = 0; end
      default: m_phase = 0;
    endcase
  endtask

  function automatic int exp_countdown();
    if (m_phase == 0) return 3;
    if (m_phase == 1) return 3 - m_cd_frames / CF;
    return 0;
  endfunction

  task automatic compare_all();
    check_eq("state", int'(state), m_phase);
    check_eq("countdown", int'(countdown), exp_countdown());
    check_eq("lap_cnt", int'(lap_cnt), m_laps);
    check_eq("frame_time", int'(frame_time), m_ft);
    check_eq("bg_visible", int'(bg_visible), 1);
    check_eq("track_visible", int'(track_visible), (m_phase != 0) ? 1 : 0);
    check_eq("player_visible", int'(player_visible), (m_phase != 0) ? 1 : 0);
    check_eq("car_en", int'(car_en), (m_phase == 2) ? 1 : 0);
  endtask

  // Called at a falling edge; applies inputs, clocks once, checks, returns at the next falling edge.
  task automatic cyc(input bit v, input logic [3:0] k, input bit lp, input bit cr);
    vblnk = v; key = k; lap_pulse = lp; crash = cr;
    @(posedge pclk);
    model_step(v, k, lp, cr);
    #1;
    compare_all();
    @(negedge pclk);
  endtask

  task automatic frame(input int n, input bit cr);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 4'b0, 1'b0, cr);
      cyc(1'b0, 4'b0, 1'b0, cr);
    end
  endtask

  task automatic press_key();
    cyc(1'b0, 4'b0100, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, int'(state), 0);
    check_eq({tag, "_countdown"}, int'(countdown), 3);
    check_eq({tag, "_lap"}, int'(lap_cnt), 0);
    check_eq({tag, "_ft"}, int'(frame_time), 0);
    check_eq({tag, "_bg"}, int'(bg_visible), 1);
    check_eq({tag, "_player"}, int'(player_visible), 0);
    check_eq({tag, "_car_en"}, int'(car_en), 0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_vals(tag);
    model_reset();
    @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  initial begin
    bit vr, crr;
    logic [3:0] kr;
    model_reset();
    // Reset with a key held: releasing it later must not count as a press.
    repeat (2) @(posedge pclk);
    #1 check_reset_vals("rst");
    @(negedge pclk);
    rst = 1'b0;
    cyc(1'b0, 4'b0001, 1'b0, 1'b0);
    cyc(1'b0, 4'b0001, 1'b0, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    frame(3, 1'b0);
    check_eq("t1_state", int'(state), 0);
    check_eq("t1_player", int'(player_visible), 0);

    cyc(1'b0, 4'b0001, 1'b0, 1'b0);
    check_eq("t2_state", int'(state), 1);
    check_eq("t2_cd3", int'(countdown), 3);
    cyc(1'b0, 4'b0000, 1'b0, 1'b0);
    frame(2, 1'b0);
    check_eq("t2_cd2", int'(countdown), 2);
    frame(2, 1'b0);
    check_eq("t2_cd1", int'(countdown), 1);
    frame(2, 1'b0);
    check_eq("t2_race", int'(state), 2);
    check_eq("t2_car_en", int'(car_en), 1);
    check_eq("t2_cd0", int'(countdown), 0);

    frame(5, 1'b0);
    check_eq("t3_ft5", int'(frame_time), 5);
    cyc(1'b0, 4'b0, 1'b1, 1'b0);
    check_eq("t3_lap1", int'(lap_cnt), 1);
    cyc(1'b0, 4'b0, 1'b1, 1'b0);
    check_eq("t3_finish", int'(state), 4);
    check_eq("t3_car_en", int'(car_en), 0);
    frame(3, 1'b0);
    check_eq("t3_ft_frozen", int'(frame_time), 5);
    check_eq("t3_lap_frozen", int'(lap_cnt), 2);

    press_key();
    check_eq("t3_idle", int'(state), 0);
    press_key();
    frame(6, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b1);
    check_eq("t4_crash", int'(state), 3);
    check_eq("t4_car_en", int'(car_en), 0);
    cyc(1'b0, 4'b0, 1'b1, 1'b0);
    check_eq("t4_lap_ign", int'(lap_cnt), 0);
    frame(3, 1'b0);
    check_eq("t4_back_race", int'(state), 2);
    check_eq("t4_ft3", int'(frame_time), 3);

    cyc(1'b0, 4'b0, 1'b1, 1'b0);
    cyc(1'b0, 4'b0, 1'b1, 1'b1);
    check_eq("t5_finish", int'(state), 4);
    check_eq("t5_lap2", int'(lap_cnt), 2);

    press_key();
    press_key();
    frame(6, 1'b0);
    frame(2, 1'b0);
    cyc(1'b0, 4'b0, 1'b0, 1'b1);
    frame(1, 1'b0);
    check_eq("t6_in_crash", int'(state), 3);
    async_reset("t6");

    vr = 1'b0; crr = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 3) == 0) vr = ~vr;
      if ($urandom_range(0, 9) == 0) crr = ~crr;
      kr = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      cyc(vr, kr, ($urandom_range(0, 199) == 0), crr);
      if (i == 3000) async_reset("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
